// File: rtl/conv_pic_server_pkg.sv
// Shared types and sizing helpers for the convolution picture server.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum plus constant functions that derive buffer
// sizes and address widths from the engine geometry parameters.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } conv_state_t;

    // Words in one input picture across all channels.
    function automatic int pix_total(input int ch, input int ps);
        return ch * ps * ps;
    endfunction

    // Words reserved per result map (the full picture footprint, so the
    // engine can address results in picture coordinates).
    function automatic int map_words(input int ps);
        return ps * ps;
    endfunction

    // Edge of the valid convolution output.
    function automatic int out_size(input int ps, input int ks);
        return ps - ks + 1;
    endfunction

    // Result beats the engine emits for one complete output map.
    function automatic int map_beats(input int ps, input int ks);
        return out_size(ps, ks) * out_size(ps, ks);
    endfunction

    // Address width for a memory of the given depth, never below 1 bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_pic_server_if.sv
// Engine-side bus between the picture server (master) and the conv engine.
// Latency: n/a (wires only).
// Backpressure: engine paces pixels with need_pic; results are strobed, never stalled.
// Signals: conv_start, pic, pic_valid (server -> engine);
//          need_pic, conv_finish, conv_result_valid, conv_result,
//          conv_result_addr (engine -> server).
interface conv_pic_server_if #(
    parameter int WIDTH  = 8,
    parameter int RES_AW = 10
);
    logic              conv_start;
    logic              need_pic;
    logic [WIDTH-1:0]  pic;
    logic              pic_valid;
    logic              conv_finish;
    logic              conv_result_valid;
    logic [WIDTH-1:0]  conv_result;
    logic [RES_AW-1:0] conv_result_addr;

    modport master (
        output conv_start,
        output pic,
        output pic_valid,
        input  need_pic,
        input  conv_finish,
        input  conv_result_valid,
        input  conv_result,
        input  conv_result_addr
    );

    modport slave (
        input  conv_start,
        input  pic,
        input  pic_valid,
        output need_pic,
        output conv_finish,
        output conv_result_valid,
        output conv_result,
        output conv_result_addr
    );
endinterface

// File: rtl/conv_sp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid 1 cycle after raddr; same-address write/read returns old data.
// Backpressure: none, accepts a write and a read every cycle.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata, raddr/rdata.
module conv_sp_ram
    import conv_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/conv_pic_server.sv
// Host-side picture server: buffers one input picture, starts the conv engine,
// serves pixels on need_pic and captures result beats into per-kernel maps.
// Latency: conv_start 1 cycle after run; next pixel 1 cycle after a consume; rd_data 1 cycle.
// Backpressure: pixels advance only on need_pic && pic_valid; results are never stalled.
// Ports: clk, rst_n; wr_en/wr_addr/wr_data (picture load); run/busy/done (control);
//        rd_addr/rd_data (result readback); eng (engine bus, master side);
//        stall_cycles (only with CONV_STALL_CNT_EN defined).
module conv_pic_server
    import conv_pkg::*;
#(
    parameter  int WIDTH         = 8,
    parameter  int kernel_size   = 5,
    parameter  int pic_size      = 28,
    parameter  int channel       = 3,
    parameter  int kernel_number = 4,
    parameter  int SIGN          = 1,
    parameter  int FP_POSITIONS  = 4,
    localparam int PIX_TOTAL     = pix_total(channel, pic_size),
    localparam int MAP_WORDS     = map_words(pic_size),
    localparam int RES_DEPTH     = kernel_number * MAP_WORDS,
    localparam int PIX_AW        = addr_w(PIX_TOTAL),
    localparam int RES_AW        = addr_w(RES_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [PIX_AW-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              run,
    output logic              busy,
    output logic              done,
    input  logic [RES_AW-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
`ifdef CONV_STALL_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    conv_pic_server_if.master eng
);

    localparam int MAP_BEATS = map_beats(pic_size, kernel_size);
    localparam int BC_W      = addr_w(MAP_BEATS);
    localparam int KI_W      = addr_w(kernel_number);

    // Sign and fixed-point position are carried for parameter compatibility
    // with the engine only; data is handled as raw bits here.
    logic unused_cfg;
    assign unused_cfg = (SIGN != 0) ^ (FP_POSITIONS != 0);

    conv_state_t       state;
    logic              conv_start_q;
    logic              pic_valid_q;
    logic [WIDTH-1:0]  pic_q;

    logic [PIX_AW-1:0] pix_ptr;
    logic [PIX_AW-1:0] pix_ptr_nxt;
    logic [PIX_AW-1:0] pix_rd_addr;
    logic [BC_W-1:0]   beat_cnt;
    logic [KI_W-1:0]   kern_idx;
    logic [RES_AW-1:0] res_wr_addr;

    logic              run_acc;
    logic              consume;
    logic              capture;

    assign eng.conv_start = conv_start_q;
    assign eng.pic_valid  = pic_valid_q;
    assign eng.pic        = pic_q;

    assign run_acc = (state == IDLE) && run;
    assign consume = pic_valid_q && eng.need_pic;
    assign capture = eng.conv_result_valid && ((state == START) || (state == STREAM));

    // Picture replays from the start once the last word is consumed.
    assign pix_ptr_nxt = (pix_ptr == PIX_AW'(PIX_TOTAL - 1)) ? '0 : pix_ptr + PIX_AW'(1);

    // The pixel RAM read is registered, so look one word ahead on a consume
    // to keep full-rate back-to-back delivery.
    assign pix_rd_addr = consume ? pix_ptr_nxt : pix_ptr;

    assign res_wr_addr = RES_AW'(int'(kern_idx) * MAP_WORDS + int'(eng.conv_result_addr));

    // Control FSM; all handshake outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            conv_start_q <= 1'b0;
            pic_valid_q  <= 1'b0;
        end else begin
            conv_start_q <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state        <= START;
                        conv_start_q <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                START: begin
                    state       <= STREAM;
                    pic_valid_q <= 1'b1;
                end
                STREAM: begin
                    if (eng.conv_finish) begin
                        state       <= DONE;
                        pic_valid_q <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    pic_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ptr <= '0;
        end else if (run_acc) begin
            pix_ptr <= '0;
        end else if (consume) begin
            pix_ptr <= pix_ptr_nxt;
        end
    end

    // Result map tracking: a full map of beats advances to the next kernel;
    // the last kernel absorbs any surplus beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            kern_idx <= '0;
        end else if (run_acc) begin
            beat_cnt <= '0;
            kern_idx <= '0;
        end else if (capture) begin
            if (beat_cnt == BC_W'(MAP_BEATS - 1)) begin
                beat_cnt <= '0;
                if (kern_idx != KI_W'(kernel_number - 1)) begin
                    kern_idx <= kern_idx + KI_W'(1);
                end
            end else begin
                beat_cnt <= beat_cnt + BC_W'(1);
            end
        end
    end

`ifdef CONV_STALL_CNT_EN
    // Cycles the engine left a presented pixel waiting, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (run_acc) begin
            stall_cycles <= '0;
        end else if ((state == STREAM) && !eng.need_pic && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    conv_sp_ram #(
        .DW    (WIDTH),
        .DEPTH (PIX_TOTAL)
    ) u_pic_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pix_rd_addr),
        .rdata (pic_q)
    );

    conv_sp_ram #(
        .DW    (WIDTH),
        .DEPTH (RES_DEPTH)
    ) u_res_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (capture),
        .waddr (res_wr_addr),
        .wdata (eng.conv_result),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_conv_pic_server.sv
// Self-checking bench for conv_pic_server: randomized picture and result traffic,
// expected pixels / readback words queued at stimulus time, popped by a monitor.
module tb_conv_pic_server;

    localparam int PS        = 28;
    localparam int KS        = 5;
    localparam int CH        = 3;
    localparam int KN        = 4;
    localparam int PIX_TOTAL = CH * PS * PS;
    localparam int MAP_WORDS = PS * PS;
    localparam int OUT_EDGE  = PS - KS + 1;
    localparam int MAP_BEATS = OUT_EDGE * OUT_EDGE;
    localparam int RES_DEPTH = KN * MAP_WORDS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        run;
    logic        busy;
    logic        done;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
`ifdef CONV_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    conv_pic_server_if #(.WIDTH(8), .RES_AW(10)) eng ();

    conv_pic_server dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .run     (run),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
`ifdef CONV_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .eng     (eng)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] pic_mem [PIX_TOTAL];
    logic [7:0] res_mem [RES_DEPTH];
    bit         res_wr  [RES_DEPTH];
    int         pix_idx;
    int         beat_n;
    int         mdl_stall;
    bit         mdl_stream;
    bit         mdl_cap;

    logic [7:0] exp_pix [$];
    logic [7:0] exp_rd  [$];
    bit         rd_req;
    bit         rd_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, between drive and capture.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_pending) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_data: read with no expected word, got 0x%0h", rd_data);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                end
            end
            rd_pending = rd_req;
            if (eng.pic_valid && eng.need_pic) begin
                if (exp_pix.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pic: unexpected consume, got 0x%0h", eng.pic);
                end else begin
                    check("pic", 32'(eng.pic), 32'(exp_pix.pop_front()));
                end
            end
        end else begin
            rd_pending = 1'b0;
        end
    end

    task automatic step();
        if (mdl_stream && !eng.need_pic) mdl_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input bit np);
        eng.need_pic = np;
        if (np) begin
            exp_pix.push_back(pic_mem[pix_idx % PIX_TOTAL]);
            pix_idx++;
        end
        step();
    endtask

    task automatic beat(input int addr, input logic [7:0] data, input bit do_rd);
        int map;
        int a;
        eng.conv_result_valid = 1'b1;
        eng.conv_result_addr  = 10'(addr);
        eng.conv_result       = data;
        if (mdl_cap) begin
            map = beat_n / MAP_BEATS;
            if (map > KN - 1) map = KN - 1;
            a = map * MAP_WORDS + addr;
            if (do_rd && res_wr[a]) begin
                // Same-cycle read of the word being written returns old data.
                rd_addr = 12'(a);
                rd_req  = 1'b1;
                exp_rd.push_back(res_mem[a]);
            end
            res_mem[a] = data;
            res_wr[a]  = 1'b1;
            beat_n++;
        end
        step();
        eng.conv_result_valid = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_addr = 12'(a);
        rd_req  = 1'b1;
        exp_rd.push_back(res_mem[a]);
        step();
        rd_req = 1'b0;
    endtask

    task automatic start_run();
        check("busy_before_run", 32'(busy), 32'd0);
        run = 1'b1;
        step();
        run = 1'b0;
        mdl_cap = 1'b1;
        pix_idx = 0;
        beat_n = 0;
        mdl_stall = 0;
        check("conv_start_pulse", 32'(eng.conv_start), 32'd1);
        check("busy_in_start", 32'(busy), 32'd1);
        check("pic_valid_in_start", 32'(eng.pic_valid), 32'd0);
        step();
        mdl_stream = 1'b1;
        check("conv_start_end", 32'(eng.conv_start), 32'd0);
        check("pic_valid_stream", 32'(eng.pic_valid), 32'd1);
        check("busy_stream", 32'(busy), 32'd1);
    endtask

    task automatic finish_run();
        eng.conv_finish = 1'b1;
        beat($urandom_range(0, MAP_WORDS - 1), 8'($urandom), 1'b0);
        eng.conv_finish = 1'b0;
        mdl_stream = 1'b0;
        mdl_cap = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("pic_valid_in_done", 32'(eng.pic_valid), 32'd0);
        // Beat while in DONE must be dropped (model does not record it).
        beat(5, 8'h5A, 1'b0);
        check("done_end", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        run = 1'b0; rd_addr = '0; rd_req = 1'b0; rd_pending = 1'b0;
        eng.need_pic = 1'b0; eng.conv_finish = 1'b0;
        eng.conv_result_valid = 1'b0; eng.conv_result = '0; eng.conv_result_addr = '0;
        mdl_stream = 1'b0; mdl_cap = 1'b0; mdl_stall = 0; pix_idx = 0; beat_n = 0;
        for (int i = 0; i < RES_DEPTH; i++) res_wr[i] = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_conv_start", 32'(eng.conv_start), 32'd0);
        check("rst_pic", 32'(eng.pic), 32'd0);
        check("rst_pic_valid", 32'(eng.pic_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Load a random picture.
        for (int i = 0; i < PIX_TOTAL; i++) begin
            wr_en = 1'b1;
            wr_addr = 12'(i);
            wr_data = 8'($urandom);
            pic_mem[i] = wr_data;
            step();
        end
        wr_en = 1'b0;
        check("conv_start_idle", 32'(eng.conv_start), 32'd0);

        start_run();
        // Full-rate stream, then a one-cycle hold, then random pacing past the wrap.
        repeat (5) pix(1'b1);
        pix(1'b1); pix(1'b0); pix(1'b1);
        while (pix_idx < PIX_TOTAL + 2) pix($urandom_range(0, 3) != 0);
        eng.need_pic = 1'b0;

        // One full map of patterned beats, then the first beat of map 1.
        for (int k = 0; k < MAP_BEATS; k++) beat(k, 8'(k + 1), 1'b0);
        beat(0, 8'hAA, 1'b0);
        rd(5);
        rd(MAP_WORDS);
        // Random beats running into kernel saturation, with collision reads.
        repeat (1800) begin
            if ($urandom_range(0, 4) == 0) step();
            beat($urandom_range(0, MAP_WORDS - 1), 8'($urandom), $urandom_range(0, 3) == 0);
        end
        finish_run();
`ifdef CONV_STALL_CNT_EN
        check("stall_cycles_run1", stall_cycles, 32'(mdl_stall));
`endif
        // Beat in IDLE is dropped as well.
        beat(MAP_WORDS, 8'h3C, 1'b0);

        for (int a = 0; a < RES_DEPTH; a++) if (res_wr[a]) rd(a);
        repeat (2) step();

        // Reset mid-stream, then rerun: pixels restart from word 0.
        start_run();
        repeat (3) pix(1'b1);
        eng.need_pic = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mdl_stream = 1'b0;
        mdl_cap = 1'b0;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pic_valid", 32'(eng.pic_valid), 32'd0);
        check("arst_pic", 32'(eng.pic), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        start_run();
        pix(1'b1); pix(1'b0); pix(1'b0); pix(1'b1); pix(1'b0); pix(1'b1);
        eng.need_pic = 1'b0;
`ifdef CONV_STALL_CNT_EN
        check("stall_cycles_rerun", stall_cycles, 32'(mdl_stall));
`endif
        finish_run();
        repeat (3) step();

        check("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
